// File: rtl/cache_mem_arbiter_pkg.sv
// Shared definitions for the cache/memory port arbiter: default widths,
// owner encoding and the burst FSM state type.
package cache_mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 8;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_RDATA = 3'd2,
        ST_WDATA = 3'd3,
        ST_WRESP = 3'd4
    } arb_state_e;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundles the I-cache, D-cache and external memory signals of the arbiter.
// The master modport is the arbiter's view; slave is the surrounding system.
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [LEN_W-1:0]  i_len;
    logic [DATA_W-1:0] i_rdata;
    logic              i_rvalid;
    logic              i_done;
    logic              i_busy;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [LEN_W-1:0]  d_len;
    logic [DATA_W-1:0] d_wdata;
    logic              d_wnext;
    logic [DATA_W-1:0] d_rdata;
    logic              d_rvalid;
    logic              d_done;
    logic              d_busy;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LEN_W-1:0]  mem_len;
    logic              mem_addr_ok;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;
    logic              mem_rlast;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wvalid;
    logic              mem_wlast;
    logic              mem_wready;
    logic              mem_bvalid;

    modport master (
        input  i_req, i_addr, i_len,
        output i_rdata, i_rvalid, i_done, i_busy,
        input  d_req, d_we, d_addr, d_len, d_wdata,
        output d_wnext, d_rdata, d_rvalid, d_done, d_busy,
        output mem_req, mem_we, mem_addr, mem_len,
        input  mem_addr_ok, mem_rdata, mem_rvalid, mem_rlast,
        output mem_wdata, mem_wvalid, mem_wlast,
        input  mem_wready, mem_bvalid
    );

    modport slave (
        output i_req, i_addr, i_len,
        input  i_rdata, i_rvalid, i_done, i_busy,
        output d_req, d_we, d_addr, d_len, d_wdata,
        input  d_wnext, d_rdata, d_rvalid, d_done, d_busy,
        input  mem_req, mem_we, mem_addr, mem_len,
        output mem_addr_ok, mem_rdata, mem_rvalid, mem_rlast,
        input  mem_wdata, mem_wvalid, mem_wlast,
        output mem_wready, mem_bvalid
    );
endinterface

// File: rtl/cache_mem_arbiter_rr_grant2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to the
// side that did not win last time. The winner is remembered only when i_en is high.
module rr_grant2
    import cache_mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic       o_valid,
    output logic       o_owner
);
    logic r_last;

    // Pick the winner from the current request pair.
    always_comb begin
        o_valid = |i_req;
        case (i_req)
            2'b01:   o_owner = OWN_I;
            2'b10:   o_owner = OWN_D;
            2'b11:   o_owner = ~r_last;
            default: o_owner = OWN_I;
        endcase
    end

    // Remember the last winner; reset favours I on the first tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last <= OWN_D;
        end else if (i_en && o_valid) begin
            r_last <= o_owner;
        end else begin
            r_last <= r_last;
        end
    end
endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the external memory port between I-cache refills and D-cache
// accesses, holding one owner for a whole address + data burst.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic                 clk,
    input  logic                 resetn,
    cache_mem_arbiter_if.master  bus
);
    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_cnt;

    logic w_gnt_valid;
    logic w_gnt_owner;
    logic w_grant;
    logic w_rbeat;
    logic w_rdone;
    logic w_wbeat;
    logic w_wlast;
    logic w_bdone;

    rr_grant2 u_rr_grant2 (
        .clk     (clk),
        .resetn  (resetn),
        .i_req   ({bus.d_req, bus.i_req}),
        .i_en    (r_state == ST_IDLE),
        .o_valid (w_gnt_valid),
        .o_owner (w_gnt_owner)
    );

    assign w_grant = (r_state == ST_IDLE) && w_gnt_valid;
    assign w_rbeat = (r_state == ST_RDATA) && bus.mem_rvalid;
    assign w_rdone = w_rbeat && bus.mem_rlast;
    assign w_wlast = (r_cnt == r_len);
    assign w_wbeat = (r_state == ST_WDATA) && bus.mem_wready;
    assign w_bdone = (r_state == ST_WRESP) && bus.mem_bvalid;

    // Burst FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = w_gnt_valid ? ST_ADDR : ST_IDLE;
            ST_ADDR:  w_state_nxt = bus.mem_addr_ok ? (r_we ? ST_WDATA : ST_RDATA) : ST_ADDR;
            ST_RDATA: w_state_nxt = w_rdone ? ST_IDLE : ST_RDATA;
            ST_WDATA: w_state_nxt = (w_wbeat && w_wlast) ? ST_WRESP : ST_WDATA;
            ST_WRESP: w_state_nxt = w_bdone ? ST_IDLE : ST_WRESP;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant latches and beat counter; rlast terminates even if the count disagrees.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_owner <= OWN_I;
            r_we    <= 1'b0;
            r_addr  <= {ADDR_W{1'b0}};
            r_len   <= {LEN_W{1'b0}};
            r_cnt   <= {LEN_W{1'b0}};
        end else if (w_grant) begin
            r_owner <= w_gnt_owner;
            r_we    <= (w_gnt_owner == OWN_D) ? bus.d_we : 1'b0;
            r_addr  <= (w_gnt_owner == OWN_D) ? bus.d_addr : bus.i_addr;
            r_len   <= (w_gnt_owner == OWN_D) ? bus.d_len : bus.i_len;
            r_cnt   <= {LEN_W{1'b0}};
        end else if (w_rbeat || (w_wbeat && !w_wlast)) begin
            r_cnt   <= r_cnt + {{(LEN_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt   <= r_cnt;
        end
    end

    // Output decode: read data goes only to the owner, write data only from D.
    always_comb begin
        bus.i_rdata    = {DATA_W{1'b0}};
        bus.i_rvalid   = 1'b0;
        bus.i_done     = 1'b0;
        bus.d_rdata    = {DATA_W{1'b0}};
        bus.d_rvalid   = 1'b0;
        bus.d_done     = 1'b0;
        bus.d_wnext    = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = r_we;
        bus.mem_addr   = r_addr;
        bus.mem_len    = r_len;
        bus.mem_wdata  = {DATA_W{1'b0}};
        bus.mem_wvalid = 1'b0;
        bus.mem_wlast  = 1'b0;
        case (r_state)
            ST_ADDR: bus.mem_req = 1'b1;
            ST_RDATA: begin
                if (r_owner == OWN_D) begin
                    bus.d_rdata  = bus.mem_rdata;
                    bus.d_rvalid = bus.mem_rvalid;
                    bus.d_done   = w_rdone;
                end else begin
                    bus.i_rdata  = bus.mem_rdata;
                    bus.i_rvalid = bus.mem_rvalid;
                    bus.i_done   = w_rdone;
                end
            end
            ST_WDATA: begin
                bus.mem_wdata  = bus.d_wdata;
                bus.mem_wvalid = 1'b1;
                bus.mem_wlast  = w_wlast;
                bus.d_wnext    = bus.mem_wready;
            end
            ST_WRESP: bus.d_done = bus.mem_bvalid;
            default:  bus.mem_req = 1'b0;
        endcase
        bus.i_busy = bus.i_req && !bus.i_done;
        bus.d_busy = bus.d_req && !bus.d_done;
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: the bench plays both caches and the memory,
// predicting ownership, routing and beat counts from the arbitration rules.
module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic resetn;
    int   n_pass  = 0;
    int   n_total = 0;
    bit   m_last;

    cache_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

    cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Both caches must never see a done pulse or read beat in the same cycle.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            n_total++;
            if ((bus.i_done && bus.d_done) || (bus.i_rvalid && bus.d_rvalid))
                $display("FAIL excl_owner: i_done=%b d_done=%b i_rvalid=%b d_rvalid=%b want at most one side",
                         bus.i_done, bus.d_done, bus.i_rvalid, bus.d_rvalid);
            else n_pass++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_req = 1'b0; bus.i_addr = '0; bus.i_len = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_len = '0; bus.d_wdata = '0;
        bus.mem_addr_ok = 1'b0; bus.mem_rdata = '0; bus.mem_rvalid = 1'b0; bus.mem_rlast = 1'b0;
        bus.mem_wready = 1'b0; bus.mem_bvalid = 1'b0;
    endtask

    // Called in the IDLE cycle with requests already presented; d selects the expected winner.
    task automatic serve(input bit d, input bit raise_other, input int stall_beat);
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [DW-1:0] data;
        int            gap;
        int            wn;
        bit            v;
        bit            last;
        we   = d ? bus.d_we : 1'b0;
        addr = d ? bus.d_addr : bus.i_addr;
        len  = d ? bus.d_len : bus.i_len;
        #1;
        n_total++;
        if (bus.mem_req !== 1'b0) $display("FAIL grant_cycle_req: got %b want 0", bus.mem_req);
        else n_pass++;
        m_last = d;
        cyc();
        if (raise_other) begin
            if (d) bus.i_req = 1'b1; else bus.d_req = 1'b1;
        end
        gap = $urandom_range(0, 2);
        for (int g = 0; g <= gap; g++) begin
            bus.mem_addr_ok = (g == gap);
            #1;
            n_total++;
            if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_len} !== {1'b1, we, addr, len})
                $display("FAIL addr_phase: got req=%b we=%b addr=%h len=%0d want req=1 we=%b addr=%h len=%0d",
                         bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_len, we, addr, len);
            else n_pass++;
            cyc();
        end
        bus.mem_addr_ok = 1'b0;
        if (!we) begin
            for (int b = 0; b <= int'(len); b++) begin
                gap = $urandom_range(0, 1);
                for (int g = 0; g <= gap; g++) begin
                    v    = (g == gap);
                    last = v && (b == int'(len));
                    data = $urandom;
                    bus.mem_rvalid = v; bus.mem_rlast = last; bus.mem_rdata = data;
                    #1;
                    n_total++;
                    if ({bus.i_rvalid, bus.d_rvalid, bus.i_done, bus.d_done} !==
                        (d ? {1'b0, v, 1'b0, last} : {v, 1'b0, last, 1'b0}))
                        $display("FAIL rd_route: beat %0d got iv=%b dv=%b idone=%b ddone=%b owner_d=%b want v=%b last=%b",
                                 b, bus.i_rvalid, bus.d_rvalid, bus.i_done, bus.d_done, d, v, last);
                    else n_pass++;
                    if (v) begin
                        n_total++;
                        if ((d ? bus.d_rdata : bus.i_rdata) !== data)
                            $display("FAIL rd_data: beat %0d got %h want %h", b, d ? bus.d_rdata : bus.i_rdata, data);
                        else n_pass++;
                    end
                    n_total++;
                    if ({bus.i_busy, bus.d_busy} !== (d ? {bus.i_req, ~last} : {~last, bus.d_req}))
                        $display("FAIL rd_busy: got i=%b d=%b want owner busy=%b", bus.i_busy, bus.d_busy, ~last);
                    else n_pass++;
                    cyc();
                end
            end
            bus.mem_rvalid = 1'b0; bus.mem_rlast = 1'b0;
        end else begin
            wn = 0;
            for (int b = 0; b <= int'(len); b++) begin
                bus.d_wdata = $urandom;
                gap = (b == stall_beat) ? 2 : $urandom_range(0, 1);
                for (int g = 0; g <= gap; g++) begin
                    bus.mem_wready = (g == gap);
                    #1;
                    n_total++;
                    if ({bus.mem_wvalid, bus.mem_wlast, bus.d_wnext, bus.d_done, bus.mem_wdata} !==
                        {1'b1, (b == int'(len)), (g == gap), 1'b0, bus.d_wdata})
                        $display("FAIL wr_beat: beat %0d got wv=%b wl=%b wnext=%b done=%b wdata=%h want wl=%b wnext=%b wdata=%h",
                                 b, bus.mem_wvalid, bus.mem_wlast, bus.d_wnext, bus.d_done, bus.mem_wdata,
                                 (b == int'(len)), (g == gap), bus.d_wdata);
                    else n_pass++;
                    if (bus.d_wnext === 1'b1) wn++;
                    cyc();
                end
            end
            bus.mem_wready = 1'b0;
            n_total++;
            if (wn != int'(len) + 1) $display("FAIL wr_count: got %0d wnext want %0d", wn, int'(len) + 1);
            else n_pass++;
            gap = $urandom_range(0, 2);
            for (int g = 0; g <= gap; g++) begin
                bus.mem_bvalid = (g == gap);
                #1;
                n_total++;
                if ({bus.mem_wvalid, bus.d_done, bus.i_done, bus.d_busy} !== {1'b0, (g == gap), 1'b0, (g != gap)})
                    $display("FAIL wr_resp: got wv=%b ddone=%b idone=%b dbusy=%b want ddone=%b",
                             bus.mem_wvalid, bus.d_done, bus.i_done, bus.d_busy, (g == gap));
                else n_pass++;
                cyc();
            end
            bus.mem_bvalid = 1'b0;
        end
        if (d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 1'b0;
        #12;
        n_total++;
        if ({bus.i_rdata, bus.i_rvalid, bus.i_done, bus.i_busy, bus.d_wnext, bus.d_rdata, bus.d_rvalid,
             bus.d_done, bus.d_busy, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_len, bus.mem_wdata,
             bus.mem_wvalid, bus.mem_wlast} !== '0)
            $display("FAIL reset_outputs: got req=%b addr=%h len=%0d wv=%b some output nonzero want all 0",
                     bus.mem_req, bus.mem_addr, bus.mem_len, bus.mem_wvalid);
        else n_pass++;
        @(negedge clk);
        resetn = 1'b1;
        m_last = OWN_D;
        cyc();
    endtask

    task automatic test_tie();
        bus.i_addr = $urandom; bus.i_len = 8'd2;
        bus.d_addr = $urandom; bus.d_len = 8'd1; bus.d_we = 1'b0;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        serve(OWN_I, 1'b0, -1);
        serve(OWN_D, 1'b0, -1);
        bus.i_addr = $urandom; bus.i_len = 8'd0;
        bus.d_addr = $urandom; bus.d_len = 8'd2; bus.d_we = 1'b1;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        serve(OWN_I, 1'b0, -1);
        serve(OWN_D, 1'b0, -1);
    endtask

    task automatic test_i_read();
        bus.i_addr = 32'h1fc0_0000; bus.i_len = 8'd7; bus.i_req = 1'b1;
        serve(OWN_I, 1'b0, -1);
    endtask

    task automatic test_d_write();
        bus.d_addr = 32'h0000_1000; bus.d_len = 8'd3; bus.d_we = 1'b1; bus.d_req = 1'b1;
        serve(OWN_D, 1'b0, 2);
    endtask

    task automatic test_d_read_len0();
        bus.i_addr = $urandom; bus.i_len = 8'd3;
        bus.d_addr = $urandom; bus.d_len = 8'd0; bus.d_we = 1'b0; bus.d_req = 1'b1;
        serve(OWN_D, 1'b1, -1);
        serve(OWN_I, 1'b0, -1);
    endtask

    task automatic test_reset_midburst();
        bus.i_addr = $urandom; bus.i_len = 8'd7; bus.i_req = 1'b1;
        cyc();
        bus.mem_addr_ok = 1'b1;
        cyc();
        bus.mem_addr_ok = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = $urandom;
            cyc();
        end
        bus.mem_rvalid = 1'b1; bus.mem_rdata = $urandom;
        #1;
        resetn = 1'b0;
        #1;
        n_total++;
        if ({bus.i_rvalid, bus.d_rvalid, bus.i_done, bus.d_done, bus.mem_req, bus.mem_wvalid, bus.d_wnext, bus.i_rdata} !== '0)
            $display("FAIL reset_midburst: got iv=%b dv=%b idone=%b ddone=%b req=%b rdata=%h want all 0",
                     bus.i_rvalid, bus.d_rvalid, bus.i_done, bus.d_done, bus.mem_req, bus.i_rdata);
        else n_pass++;
        clear_inputs();
        @(negedge clk);
        resetn = 1'b1;
        m_last = OWN_D;
        cyc();
        bus.i_addr = $urandom; bus.i_len = 8'd2; bus.i_req = 1'b1;
        serve(OWN_I, 1'b0, -1);
    endtask

    task automatic test_random();
        bit w;
        for (int t = 0; t < 40; t++) begin
            if (!bus.i_req && ($urandom_range(0, 1) == 1)) begin
                bus.i_addr = $urandom; bus.i_len = LW'($urandom_range(0, 5)); bus.i_req = 1'b1;
            end
            if (!bus.d_req && (($urandom_range(0, 1) == 1) || !bus.i_req)) begin
                bus.d_addr = $urandom; bus.d_len = LW'($urandom_range(0, 5));
                bus.d_we = 1'($urandom_range(0, 1)); bus.d_req = 1'b1;
            end
            w = (bus.i_req && bus.d_req) ? ~m_last : bus.d_req;
            serve(w, 1'b0, -1);
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_i_read();
        test_d_write();
        test_d_read_len0();
        test_reset_midburst();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
